// File: rtl/async_req_initiator.sv
// async_req_initiator: clocked end of a req/fin handshake with a self-timed delay stage.
// The asynchronous fin pulse is caught by a toggle flop and synchronized into clk.
module async_req_initiator #(
  parameter int SYNC_STAGES = 2,
  parameter int LOW_CYCLES  = 2,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  output logic             req,
  input  logic             fin,
  output logic             done,
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] lat,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, WAIT_FIN, REQ_LOW} state_t;

  localparam int               LOW_W    = $clog2(LOW_CYCLES + 1);
  localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  state_t                 state, state_nxt;
  logic                   fin_tgl;
  logic [SYNC_STAGES-1:0] fin_sync;
  logic                   fin_seen;
  logic [CNT_W-1:0]       cnt, cnt_inc;
  logic [LOW_W-1:0]       low_cnt;
  logic                   expire;
  logic                   req_nxt, done_nxt, timeout_nxt, err_set;

  // A toggle turns a pulse of any width into a level change the clk domain can sample.
  always_ff @(posedge fin or negedge rst_n) begin
    if (!rst_n) fin_tgl <= 1'b0;
    else        fin_tgl <= ~fin_tgl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fin_sync <= '0;
    else        fin_sync <= {fin_sync[SYNC_STAGES-2:0], fin_tgl};
  end

  assign fin_seen = fin_sync[SYNC_STAGES-1] ^ fin_sync[SYNC_STAGES-2];
  assign cnt_inc  = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  assign expire   = TO_EN && (cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start_valid)          state_nxt = WAIT_FIN;
      WAIT_FIN: if (fin_seen || expire)   state_nxt = REQ_LOW;
      REQ_LOW:  if (low_cnt == LOW_LAST)  state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // fin_seen takes priority over expiry when both land in the same cycle.
  always_comb begin
    start_ready = (state == IDLE);
    busy        = (state != IDLE);
    req_nxt     = (state_nxt == WAIT_FIN);
    done_nxt    = (state == WAIT_FIN) && fin_seen;
    timeout_nxt = (state == WAIT_FIN) && !fin_seen && expire;
    err_set     = fin_seen && (state != WAIT_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req     <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      lat     <= '0;
      err     <= 1'b0;
      cnt     <= '0;
      low_cnt <= '0;
    end else begin
      req     <= req_nxt;
      done    <= done_nxt;
      timeout <= timeout_nxt;
      if (done_nxt) lat <= cnt_inc;
      if (err_set)  err <= 1'b1;
      if (state == WAIT_FIN) cnt <= cnt_inc;
      else                   cnt <= '0;
      if (state == REQ_LOW)  low_cnt <= low_cnt + 1'b1;
      else                   low_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_async_req_initiator.sv
// Testbench for async_req_initiator: table-driven transactions checked through a scoreboard,
// plus hand sequences for back-to-back, random fin widths, saturation, late fin and reset.
module tb_async_req_initiator;
  localparam int SS = 2;
  localparam int LC = 2;
  localparam int TO = 10;

  logic       clk, rst_n, start_valid, start_ready, req, fin, done, timeout, busy, err;
  logic [7:0] lat;
  logic       fin_man, fin_auto;
  logic       s_start, s_ready, s_req, s_fin, s_done, s_tout, s_busy, s_err;
  logic [3:0] s_lat;

  assign fin = fin_man | fin_auto;

  typedef struct packed { logic is_done; logic [7:0] lat; } exp_t;
  typedef struct { int fin_delay; logic exp_done; logic [7:0] exp_lat; } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic auto_mode = 0, auto_rand = 0, b2b_chk = 0, rand_chk = 0;
  int   rsp_d, rsp_w, fin_cnt = 0;
  int   rise_cnt = 0, done_pulses = 0, high_run = 0, low_run = 0, last_high = 0;
  int   tog_total = 0, tog_seen = 0, max_tog = 0, s_tout_cnt = 0;
  logic req_q = 0, low_valid = 0;
  logic [7:0] held_lat = 0;
  exp_t mon_e;

  async_req_initiator #(.SYNC_STAGES(SS), .LOW_CYCLES(LC), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .req(req), .fin(fin), .done(done), .timeout(timeout), .busy(busy), .lat(lat), .err(err)
  );

  async_req_initiator #(.SYNC_STAGES(2), .LOW_CYCLES(2), .TIMEOUT(0), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start_valid(s_start), .start_ready(s_ready),
    .req(s_req), .fin(s_fin), .done(s_done), .timeout(s_tout), .busy(s_busy), .lat(s_lat), .err(s_err)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // The stage model: answers each req rise after a delay with a pulse of some width.
  always @(posedge req) begin
    if (auto_mode) begin
      rsp_d = auto_rand ? int'($urandom_range(6, 0)) : 1;
      rsp_w = auto_rand ? int'($urandom_range(300, 20)) : 10;
      exp_q.push_back({1'b1, 8'(rsp_d + SS)});
      repeat (rsp_d) @(posedge clk);
      #10 fin_auto = 1'b1;
      fin_cnt++;
      #(rsp_w) fin_auto = 1'b0;
    end
  end

  always @(req) tog_total++;

  always @(negedge clk) if (s_tout) s_tout_cnt++;

  // Monitor: tracks req run lengths and pops the scoreboard on every done/timeout pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      req_q = 1'b0; high_run = 0; low_run = 0; low_valid = 1'b0; held_lat = 8'd0;
    end else begin
      if (req && !req_q) begin
        rise_cnt++;
        if (b2b_chk && low_valid) checkOutput("b2b_req_low_cycles", 32'(low_run), 32'(LC + 1));
        high_run = 0;
      end
      if (!req && req_q) begin
        last_high = high_run;
        low_run   = 0;
        low_valid = b2b_chk;
      end
      if (req) high_run++; else low_run++;
      req_q = req;
      if (done) done_pulses++;
      if (done || timeout) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("[TB] FAIL sb_unexpected: got done=%0b timeout=%0b, expected no pulse", done, timeout);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("sb_done", 32'(done), 32'(mon_e.is_done));
          checkOutput("sb_timeout", 32'(timeout), 32'(!mon_e.is_done));
          if (mon_e.is_done) begin
            held_lat = mon_e.lat;
            checkOutput("sb_req_high", 32'(last_high), 32'(mon_e.lat));
          end else begin
            checkOutput("sb_req_high", 32'(last_high), 32'(TO));
          end
          checkOutput("sb_lat", 32'(lat), 32'(held_lat));
        end
      end
    end
    if (rand_chk && (tog_total - tog_seen) > max_tog) max_tog = tog_total - tog_seen;
    tog_seen = tog_total;
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req"},         32'(req), 0);
    checkOutput({tag, "_start_ready"}, 32'(start_ready), 1);
    checkOutput({tag, "_busy"},        32'(busy), 0);
    checkOutput({tag, "_done"},        32'(done), 0);
    checkOutput({tag, "_timeout"},     32'(timeout), 0);
    checkOutput({tag, "_lat"},         32'(lat), 0);
    checkOutput({tag, "_err"},         32'(err), 0);
  endtask

  task automatic waitReady();
    int k = 0;
    while (!start_ready && k < 50) begin @(negedge clk); k++; end
    checkOutput("ready_wait", 32'(start_ready), 1);
  endtask

  task automatic drainQueue(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin @(negedge clk); k++; end
    checkOutput("sb_drain", 32'(exp_q.size()), 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    waitReady();
    e.is_done = v.exp_done;
    e.lat     = v.exp_lat;
    exp_q.push_back(e);
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    if (v.fin_delay >= 0) begin
      repeat (v.fin_delay) @(posedge clk);
      #10 fin_man = 1'b1;
      #10 fin_man = 1'b0;
    end
    drainQueue(40);
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    vec_t v;
    int   r0, d0, f0, k;
    // fin_delay = clk edges after the accept edge before the fin pulse (-1: no fin).
    // Expected lat = fin_delay + SS; fin_delay 8 lands fin_seen on the expiry cycle.
    vecs[0] = '{3,  1'b1, 8'd5};
    vecs[1] = '{0,  1'b1, 8'd2};
    vecs[2] = '{1,  1'b1, 8'd3};
    vecs[3] = '{5,  1'b1, 8'd7};
    vecs[4] = '{7,  1'b1, 8'd9};
    vecs[5] = '{8,  1'b1, 8'd10};
    vecs[6] = '{-1, 1'b0, 8'd0};
    vecs[7] = '{4,  1'b1, 8'd6};
    vecs[8] = '{-1, 1'b0, 8'd0};

    rst_n = 1'b1; start_valid = 1'b0; fin_man = 1'b0; fin_auto = 1'b0;
    s_start = 1'b0; s_fin = 1'b0;
    #10 rst_n = 1'b0;
    #20 checkResetValues("init");
    #90 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);
    checkOutput("err_after_table", 32'(err), 0);

    auto_mode = 1'b1; b2b_chk = 1'b1;
    r0 = rise_cnt; d0 = done_pulses;
    start_valid = 1'b1;
    repeat (100) @(negedge clk);
    start_valid = 1'b0; b2b_chk = 1'b0;
    drainQueue(40);
    checkOutput("b2b_done_per_rise", 32'(done_pulses - d0), 32'(rise_cnt - r0));
    checkOutput("b2b_err", 32'(err), 0);

    auto_rand = 1'b1; rand_chk = 1'b1;
    r0 = rise_cnt; d0 = done_pulses; f0 = fin_cnt; k = 0;
    start_valid = 1'b1;
    while ((rise_cnt - r0) < 1000 && k < 15000) begin @(negedge clk); k++; end
    start_valid = 1'b0;
    drainQueue(40);
    rand_chk = 1'b0; auto_mode = 1'b0; auto_rand = 1'b0;
    checkOutput("rand_reached_1000", 32'((rise_cnt - r0) >= 1000), 1);
    checkOutput("rand_done_per_fin", 32'(done_pulses - d0), 32'(fin_cnt - f0));
    checkOutput("rand_req_toggles_per_cycle", 32'(max_tog), 1);
    checkOutput("rand_err", 32'(err), 0);

    checkOutput("sat_ready", 32'(s_ready), 1);
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    repeat (30) @(posedge clk);
    #10 s_fin = 1'b1;
    #10 s_fin = 1'b0;
    k = 0;
    while (!s_done && k < 20) begin @(negedge clk); k++; end
    checkOutput("sat_done", 32'(s_done), 1);
    checkOutput("sat_lat", 32'(s_lat), 15);
    checkOutput("sat_no_timeout", 32'(s_tout_cnt), 0);
    checkOutput("sat_err", 32'(s_err), 0);

    // fin arrives after expiry and is recognized in REQ_LOW.
    v = '{10, 1'b0, 8'd0};
    applyStimulus(v);
    checkOutput("late_fin_err", 32'(err), 1);
    repeat (20) @(negedge clk);
    v = '{2, 1'b1, 8'd4};
    applyStimulus(v);
    checkOutput("err_sticky", 32'(err), 1);

    waitReady();
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #20 checkOutput("pre_rst_req", 32'(req), 1);
    checkOutput("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #5 checkOutput("rst_req_async", 32'(req), 0);
    #10 fin_man = 1'b1;
    #10 fin_man = 1'b0;
    #5 checkResetValues("midrst");
    @(negedge clk);
    #10 rst_n = 1'b1;
    d0 = done_pulses;
    repeat (10) @(negedge clk);
    checkOutput("post_rst_no_done", 32'(done_pulses - d0), 0);
    checkOutput("post_rst_err", 32'(err), 0);
    checkOutput("post_rst_req", 32'(req), 0);
    checkOutput("post_rst_ready", 32'(start_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/async_req_initiator.md
# async_req_initiator

Clocked initiator for a self-timed delay stage. It accepts a start command from synchronous logic, raises `req` to the async stage, and captures the stage's short self-clearing `fin` pulse. It synchronizes that pulse back into the `clk` domain, then returns `req` low. It sits between the clocked control pipeline and an async flow-control element: the clocked-domain end of the `req`/`fin` protocol.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for the captured `fin` event (≥2).
- `LOW_CYCLES`, default 2: minimum cycles `req` stays low before the next rise (≥1).
- `TIMEOUT`, default 255: cycles to wait for `fin` after `req` rises; 0 disables the timeout.
- `CNT_W`, default 8: width of the latency counter.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  start command.
- `start_ready`  out  1  high only in IDLE.
- `req`  out  1  request to the async stage; registered and glitch-free.
- `fin`  in  1  completion pulse from the async stage; asynchronous and possibly shorter than one `clk` period.
- `done`  out  1  one-cycle pulse when `fin` is recognized.
- `timeout`  out  1  one-cycle pulse when the wait expires.
- `busy`  out  1  high in every state except IDLE.
- `lat`  out  CNT_W  cycles from `req` rise to `fin` recognition; valid when `done` pulses, held until the next `done`.
- `err`  out  1  sticky flag: a `fin` event was recognized outside WAIT_FIN. Cleared only by reset.

## Operation
- **Fin capture:** toggle flop `fin_tgl` toggles on posedge `fin` and is async-cleared by `rst_n`. It feeds a `SYNC_STAGES`-deep flop chain in `clk`. The event `fin_seen` = XOR of the last two sync bits. Each `fin` rising edge yields exactly one `fin_seen`, regardless of pulse width.
- **FSM states:** IDLE, WAIT_FIN, REQ_LOW.
- IDLE: `req`=0. On `start_valid`&&`start_ready`: go to WAIT_FIN, `req`<=1, clear the counter.
- WAIT_FIN: `req`=1, counter increments each cycle, saturating at 2^CNT_W−1.
  - On `fin_seen`: `done`<=1, `lat`<=counter+1, `req`<=0, go to REQ_LOW.
  - Else if TIMEOUT≠0 and counter==TIMEOUT−1: `timeout`<=1, `req`<=0, go to REQ_LOW.
  - If `fin_seen` and expiry occur in the same cycle, `fin_seen` wins: `done` pulses, `timeout` does not.
- REQ_LOW: `req`=0 for `LOW_CYCLES` cycles, then go to IDLE.
- Any `fin_seen` in IDLE or REQ_LOW sets `err`. This covers a late `fin` after a timeout. The event is otherwise discarded and the state does not change.
- `start_valid` outside IDLE is ignored: there is no queueing.

## Timing
- **Reset values:** `req`=0, `start_ready`=1, `busy`=0, `done`=0, `timeout`=0, `lat`=0, `err`=0, FSM=IDLE, `fin_tgl` and sync chain = 0. Reset takes effect immediately, even mid-handshake: `req` drops at once and any in-flight `fin` is forgotten.
- **Request launch:** a start accepted at edge N gives `req`=1 after edge N. `start_ready` is low from edge N.
- **Fin recognition:** a `fin` edge between edges M−1 and M gives `fin_seen` during cycle M+SYNC_STAGES−1. `done` pulses and `req` falls after the following edge.
- **Timeout path:** without `fin`, `req` is high for exactly TIMEOUT cycles. `timeout` pulses in the cycle after the last high cycle.
- **Back-to-back minimum:** the earliest next accept is `LOW_CYCLES` cycles after `req` falls. Minimum `req` period = 1 + wait + LOW_CYCLES + 1 cycles.
- **Counter saturation:** with TIMEOUT=0 the counter saturates and `lat` reports 2^CNT_W−1.

## Test plan
1. **Basic handshake:** defaults; start at cycle 5; model the stage returning a 1 ns `fin` pulse 3 cycles after `req` rises -> one `done` pulse; `lat`=3+SYNC_STAGES; `req` low for ≥2 cycles; `start_ready` returns 1.
2. **Timeout and late fin:** TIMEOUT=10, no `fin` -> `req` high exactly 10 cycles; `timeout` pulses once; `done`=0. Then drive `fin` during REQ_LOW -> `err`=1, and `err` persists until `rst_n`.
3. **Tie-break:** time the `fin` edge so `fin_seen` lands on the expiry cycle -> `done`=1, `timeout`=0.
4. **Back-to-back starts:** hold `start_valid`=1 for 100 cycles with the stage responding after 1 cycle -> every `req` rise is matched by exactly one `done`; `req` low ≥ LOW_CYCLES between rises; no `err`.
5. **Reset mid-handshake:** assert `rst_n`=0 during WAIT_FIN and fire `fin` inside the reset window -> `req`=0 immediately, all outputs at reset values, and no `done` or `err` after release.
6. **Glitch-free req:** randomized `fin` pulse widths of 0.2–3 clock periods over 1000 transactions -> `req` never toggles twice within one cycle; `done` count equals the number of `fin` edges in WAIT_FIN.
